result_fifo_drain_tx: RTL

//   Reader/transmitter end of the exponential-engine result FIFO. Pops one 21-bit result at a time
//   (rd_req/q/empty) and sends it on a 1-bit serial line as a framed word: start bit, DATA_W bits
//   LSB-first, stop bit. Sits between the FIFO and the board serial/LED pin, in the same top level

---
 rtl/result_fifo_drain_tx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/result_fifo_drain_tx.sv
// -----------------------------------------------------------------------------
// result_fifo_drain_tx
//   This block drains the exponential-engine result FIFO. It pops one word at a
//   time and transmits it on a 1-bit serial line. Each frame is a low start bit,
//   then DATA_W payload bits LSB-first, then a high stop bit. Every bit is held
//   for CLKS_PER_BIT clock cycles.
//
// Ports
//   clk          : system clock, rising edge
//   rst          : asynchronous, active-high reset
//   drain_en_i   : permission to start popping; sampled only while idle
//   empty_i      : FIFO empty flag; sampled only while idle
//   usedw_i      : FIFO fill level; registered onto fifo_level_o
//   q_i          : FIFO read data, valid the cycle after rd_req_o
//   rd_req_o     : FIFO read request, a single-cycle pulse per word
//   tx_o         : serial line, idles high
//   busy_o       : high whenever a word is being fetched or sent
//   word_done_o  : one-cycle pulse on the final cycle of each stop bit
//   words_sent_o : count of completed frames; wraps to zero
//   fifo_level_o : registered copy of usedw_i
// -----------------------------------------------------------------------------
module result_fifo_drain_tx #(
  parameter int DATA_W       = 21,
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              drain_en_i,
  input  logic              empty_i,
  input  logic [1:0]        usedw_i,
  input  logic [DATA_W-1:0] q_i,
  output logic              rd_req_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              word_done_o,
  output logic [CNT_W-1:0]  words_sent_o,
  output logic [1:0]        fifo_level_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LATCH,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t             state_q,   state_d;
  logic [DATA_W-1:0]  shift_q,   shift_d;
  logic [CW-1:0]      clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]      bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]   words_q,   words_d;
  logic [1:0]         level_q;
  logic               bit_end;

  // True on the last clock cycle of the current serial bit.
  assign bit_end = (clk_cnt_q == CLK_LAST);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    words_d   = words_q;
    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        if (drain_en_i && !empty_i) state_d = S_RD;
      end
      S_RD: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        // A normal-mode FIFO presents the popped word one cycle after rd_req.
        shift_d   = q_i;
        clk_cnt_d = '0;
        state_d   = S_START;
      end
      S_START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          shift_d   = shift_q >> 1;
          if (bit_idx_q == BIT_LAST) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          words_d   = words_q + 1'b1;
          state_d   = S_IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      words_q   <= '0;
      level_q   <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      words_q   <= words_d;
      level_q   <= usedw_i;
    end
  end

  // The outputs are decoded only from registers. Reset forces the line high
  // immediately, because the state register clears asynchronously.
  always_comb begin
    tx_o = 1'b1;
    case (state_q)
      S_START: tx_o = 1'b0;
      S_DATA:  tx_o = shift_q[0];
      default: tx_o = 1'b1;
    endcase
  end

  assign rd_req_o     = (state_q == S_RD);
  assign busy_o       = (state_q != S_IDLE);
  assign word_done_o  = (state_q == S_STOP) && bit_end;
  assign words_sent_o = words_q;
  assign fifo_level_o = level_q;

endmodule
